seg7_scan2: RTL
===============

Name: seg7_scan2

Overview:
- Downstream display stage for the 0-59 counter. Consumes the ones digit (0-9) and tens digit (0-5) produced by the digit counters.
- Drives a 2-digit common-anode multiplexed seven-segment display, with a blanking gap between digits to prevent ghosting.
- Both digits are snapshotted once per scan frame, so a displayed frame never mixes pre-carry and post-carry values.

Parameters:
- ON_CYCLES, 50000, clk cycles each digit is lit; must be >= 1.
- BLANK_CYCLES, 1000, clk cycles all anodes are off between digits; must be >= 1.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- ones_in  input  4  ones digit from counter, binary.
- tens_in  input  4  tens digit from counter, binary.
- disp_en  input  1  1 = display on; 0 = all anodes off, scanning continues.
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an_n  output  2  anodes, active-low, registered; bit0 = ones, bit1 = tens.
- frame_tick  output  1  one-cycle pulse, registered, high in the first cycle of DIG0_ON.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- States, in a fixed cycle: BLANK1 -> DIG0_ON -> BLANK0 -> DIG1_ON -> BLANK1.
- Timer: counts 0..N-1 within each state, where N = ON_CYCLES for DIGx_ON and BLANK_CYCLES for BLANKx. On timer == N-1, go to the next state and set timer to 0.
- Frame period: 2*(ON_CYCLES+BLANK_CYCLES) cycles.
- Reset values: state = BLANK1, timer = 0, snapshots = 0, seg_n = 7'h7F, an_n = 2'b11, frame_tick = 0.
  - First lit digit: an_n = 2'b10 appears exactly BLANK_CYCLES cycles after reset deasserts.
- Snapshot: on the BLANK1 -> DIG0_ON edge, load ones_in and tens_in into snapshot registers. Input changes at any other time have no effect until the next frame.
- Registered outputs: computed from the next state and updated on the same edge as the state, so outputs and state never disagree.
- an_n per state:
  - DIG0_ON: 2'b10, seg_n = decode(ones_snapshot).
  - DIG1_ON: 2'b01, seg_n = decode(tens_snapshot).
  - BLANK0 / BLANK1: 2'b11, seg_n = 7'h7F.
- Decode (active-low) for digits 0-9: 40,79,24,30,19,12,02,78,00,10 (hex).
  - Any value > 9 shows a dash: 7'h3F (segment g only).
  - The tens digit uses the same decode; tens 6-9 shows the numeral, no range check.
- disp_en:
  - disp_en = 0 forces an_n = 2'b11 and seg_n = 7'h7F at the next edge. The timer, state, snapshot and frame_tick continue unaffected.
  - Re-enabling takes effect at the next edge, showing whatever digit the current state selects.
- Reset mid-operation: all outputs return to their reset values at the next edge, regardless of state. Any partial frame is abandoned.
- Never drive both anodes low at once. Every DIGx_ON is separated by at least BLANK_CYCLES cycles of 2'b11.

Optional Feature:
- Macro: SEG7_SCAN2_LZ_BLANK_EN.
- Defined: when tens_snapshot == 0, an_n stays 2'b11 and seg_n stays 7'h7F during DIG1_ON. State timing is unchanged.
- Undefined: the tens digit 0 displays as 7'h40.

Decomposition:
- Package seg7_pkg:
  - scan state enum (BLANK1, DIG0_ON, BLANK0, DIG1_ON).
  - constants SEG_BLANK = 7'h7F, SEG_DASH = 7'h3F.
  - the 0-9 active-low segment table.
- Sub-module seg7_decode: purely combinational, 4-bit in, 7-bit active-low out. Instantiated twice or muxed once.
- Timer width: $clog2 of the larger parameter.

Test Plan (ON_CYCLES=4, BLANK_CYCLES=2):
1. Reset sequence: hold reset 3 cycles, then release with ones=3, tens=2 -> an_n = 11 for 2 cycles; then 10 with seg_n = 30 for 4 cycles; 11 for 2; 01 with seg_n = 24 for 4; frame_tick high in exactly one cycle per 12.
2. Snapshot consistency: change ones 9 -> 0 and tens 4 -> 5 two cycles into DIG0_ON -> remainder of that frame shows 10 / 19; next frame shows 40 / 12.
3. Dash: ones_in = 4'hC -> seg_n = 3F during DIG0_ON; an_n never 00 over 5 frames.
4. disp_en = 0 for 7 cycles mid-DIG1_ON -> an_n = 11 and seg_n = 7F from the next edge; frame_tick period unchanged at 12; output resumes at the next edge after re-enable.
5. Reset asserted mid-DIG0_ON -> next edge an_n = 11, seg_n = 7F, frame_tick = 0; after release, first lit digit after exactly 2 cycles.
6. With SEG7_SCAN2_LZ_BLANK_EN and tens=0, ones=7 -> DIG1_ON keeps an_n = 11; DIG0_ON shows 78. Without the macro -> DIG1_ON shows an_n = 01, seg_n = 40.

Source files
------------

// File: rtl/seg7_scan2_pkg.sv
// +--------------------------------------------------------------------------+
// | seg7_pkg : shared types and constants for the 2-digit scan display.      |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

package seg7_pkg;

  typedef enum logic [1:0] {
    ST_BLANK1  = 2'd0,
    ST_DIG0_ON = 2'd1,
    ST_BLANK0  = 2'd2,
    ST_DIG1_ON = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low {g,f,e,d,c,b,a}; element 0 is the rightmost entry.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

`default_nettype wire

// File: rtl/seg7_scan2_decode.sv
// +--------------------------------------------------------------------------+
// | seg7_decode : combinational BCD to active-low seven-segment decoder.     |
// | Rev 1.0     : initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_DASH;
    if (i_digit <= 4'd9) begin
      o_seg_n = SEG_TABLE[i_digit];
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan2.sv
// +--------------------------------------------------------------------------+
// | seg7_scan2 : 2-digit multiplexed common-anode display scanner with       |
// |              inter-digit blanking and per-frame digit snapshots.         |
// |              Define SEG7_SCAN2_LZ_BLANK_EN to blank a leading tens zero. |
// | Rev 1.0    : initial release                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_scan2
  import seg7_pkg::*;
#(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ones_in,
  input  logic [3:0] tens_in,
  input  logic       disp_en,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       frame_tick
);

  localparam int c_max_cycles = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int c_tw         = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;
  localparam logic [c_tw-1:0] c_on_last    = c_tw'(ON_CYCLES - 1);
  localparam logic [c_tw-1:0] c_blank_last = c_tw'(BLANK_CYCLES - 1);

  scan_state_t     r_state, w_state_nxt;
  logic [c_tw-1:0] r_timer, w_timer_nxt;
  logic [3:0]      r_ones, r_tens, w_ones_nxt, w_tens_nxt;
  logic [6:0]      w_seg_ones, w_seg_tens, w_seg_nxt;
  logic [1:0]      w_an_nxt;
  logic            w_done, w_load, w_tick_nxt;

  seg7_decode u_dec_ones (.i_digit(w_ones_nxt), .o_seg_n(w_seg_ones));
  seg7_decode u_dec_tens (.i_digit(w_tens_nxt), .o_seg_n(w_seg_tens));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_BLANK1;
      r_timer    <= '0;
      r_ones     <= 4'd0;
      r_tens     <= 4'd0;
      seg_n      <= SEG_BLANK;
      an_n       <= 2'b11;
      frame_tick <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_ones     <= w_ones_nxt;
      r_tens     <= w_tens_nxt;
      seg_n      <= w_seg_nxt;
      an_n       <= w_an_nxt;
      frame_tick <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + c_tw'(1);
    w_an_nxt    = 2'b11;
    w_seg_nxt   = SEG_BLANK;

    if (r_state == ST_DIG0_ON || r_state == ST_DIG1_ON) begin
      w_done = (r_timer == c_on_last);
    end else begin
      w_done = (r_timer == c_blank_last);
    end

    if (w_done) begin
      w_timer_nxt = '0;
      case (r_state)
        ST_BLANK1:  w_state_nxt = ST_DIG0_ON;
        ST_DIG0_ON: w_state_nxt = ST_BLANK0;
        ST_BLANK0:  w_state_nxt = ST_DIG1_ON;
        default:    w_state_nxt = ST_BLANK1;
      endcase
    end

    // Snapshot on frame start so a frame never mixes pre- and post-carry digits.
    w_load     = (r_state == ST_BLANK1) && w_done;
    w_tick_nxt = w_load;
    w_ones_nxt = w_load ? ones_in : r_ones;
    w_tens_nxt = w_load ? tens_in : r_tens;

    if (disp_en) begin
      case (w_state_nxt)
        ST_DIG0_ON: begin
          w_an_nxt  = 2'b10;
          w_seg_nxt = w_seg_ones;
        end
        ST_DIG1_ON: begin
`ifdef SEG7_SCAN2_LZ_BLANK_EN
          if (w_tens_nxt != 4'd0) begin
            w_an_nxt  = 2'b01;
            w_seg_nxt = w_seg_tens;
          end
`else
          w_an_nxt  = 2'b01;
          w_seg_nxt = w_seg_tens;
`endif
        end
        default: begin
          w_an_nxt  = 2'b11;
          w_seg_nxt = SEG_BLANK;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
